// File: rtl/ctrl_pkg.sv
// +------------------------------------------------------------------+
// | ctrl_pkg : shared encodings for the multi-cycle control FSM      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  localparam logic [2:0] c_op_rtype = 3'b000;
  localparam logic [2:0] c_op_addi  = 3'b001;
  localparam logic [2:0] c_op_lw    = 3'b010;
  localparam logic [2:0] c_op_sw    = 3'b011;
  localparam logic [2:0] c_op_beq   = 3'b100;
  localparam logic [2:0] c_op_j     = 3'b101;

  localparam logic [1:0] c_alu_add = 2'b00;
  localparam logic [1:0] c_alu_sub = 2'b01;
  localparam logic [1:0] c_alu_and = 2'b10;
  localparam logic [1:0] c_alu_or  = 2'b11;

  localparam logic [1:0] c_pc_inc    = 2'b00;
  localparam logic [1:0] c_pc_branch = 2'b01;
  localparam logic [1:0] c_pc_jump   = 2'b10;

  typedef struct packed {
    logic rtype;
    logic addi;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic illegal;
  } opclass_t;

endpackage

`default_nettype wire

// File: rtl/ctrl_opclass.sv
// +------------------------------------------------------------------+
// | ctrl_opclass : opcode to one-hot instruction class flags         |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module ctrl_opclass
  import ctrl_pkg::*;
(
  input  logic [2:0] opcode_i,
  output opclass_t   cls_o
);

  always_comb begin
    cls_o = '0;
    case (opcode_i)
      c_op_rtype: cls_o.rtype   = 1'b1;
      c_op_addi:  cls_o.addi    = 1'b1;
      c_op_lw:    cls_o.lw      = 1'b1;
      c_op_sw:    cls_o.sw      = 1'b1;
      c_op_beq:   cls_o.beq     = 1'b1;
      c_op_j:     cls_o.j       = 1'b1;
      default:    cls_o.illegal = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/control_fsm.sv
// +------------------------------------------------------------------+
// | control_fsm : multi-cycle CPU control (fetch/decode/exec/mem/wb) |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module control_fsm
  import ctrl_pkg::*;
#(
  parameter int IW = 16,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  output logic          instr_req,
  input  logic          instr_ack,
  input  logic [IW-1:0] instr_rdata,
  output logic [IW-1:0] ir,
  input  logic          alu_zero,
  output logic          dmem_req,
  output logic          dmem_we,
  input  logic          dmem_ack,
  output logic          pc_en,
  output logic [1:0]    pc_sel,
  output logic          rf_we,
  output logic          rf_wsel,
  output logic          alu_src,
  output logic [1:0]    alu_op,
  output logic          illegal,
  output logic [2:0]    state,
  output logic [CW-1:0] instr_count
);

  state_e        state_q, state_d;
  logic [IW-1:0] ir_q, ir_d;
  logic [CW-1:0] count_q, count_d;
  logic          illegal_q, illegal_d;
  logic          w_retire;
  opclass_t      w_cls;

  ctrl_opclass u_opclass (
    .opcode_i (ir_q[15:13]),
    .cls_o    (w_cls)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      ir_q      <= '0;
      count_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      count_q   <= count_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    w_retire  = 1'b0;
    instr_req = 1'b0;
    pc_en     = 1'b0;
    pc_sel    = c_pc_inc;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    rf_we     = 1'b0;
    rf_wsel   = 1'b0;
    alu_src   = 1'b0;
    alu_op    = c_alu_add;

    case (state_q)
      S_FETCH: begin
        instr_req = run;
        if (run && instr_ack) begin
          ir_d    = instr_rdata;
          pc_en   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (w_cls.j) begin
          pc_en    = 1'b1;
          pc_sel   = c_pc_jump;
          w_retire = 1'b1;
          state_d  = S_FETCH;
        end else if (w_cls.illegal) begin
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (w_cls.rtype) begin
          alu_op  = ir_q[12:11];
          state_d = S_WB;
        end else if (w_cls.beq) begin
          alu_op   = c_alu_sub;
          pc_en    = alu_zero;
          pc_sel   = alu_zero ? c_pc_branch : c_pc_inc;
          w_retire = 1'b1;
          state_d  = S_FETCH;
        end else begin
          // ADDI, LW and SW all compute base + immediate
          alu_src = 1'b1;
          state_d = w_cls.addi ? S_WB : S_MEM;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = w_cls.sw;
        if (dmem_ack) begin
          w_retire = w_cls.sw;
          state_d  = w_cls.sw ? S_FETCH : S_WB;
        end
      end
      S_WB: begin
        rf_we    = 1'b1;
        rf_wsel  = w_cls.lw;
        w_retire = 1'b1;
        state_d  = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase

    count_d = w_retire ? count_q + {{(CW-1){1'b0}}, 1'b1} : count_q;
  end

  assign ir          = ir_q;
  assign illegal     = illegal_q;
  assign state       = state_q;
  assign instr_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_control_fsm.sv
// +------------------------------------------------------------------+
// | tb_control_fsm : directed + randomized bench for control_fsm     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_control_fsm;

  localparam int IW = 16;
  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic          run;
  logic          instr_req;
  logic          instr_ack;
  logic [IW-1:0] instr_rdata;
  logic [IW-1:0] ir;
  logic          alu_zero;
  logic          dmem_req;
  logic          dmem_we;
  logic          dmem_ack;
  logic          pc_en;
  logic [1:0]    pc_sel;
  logic          rf_we;
  logic          rf_wsel;
  logic          alu_src;
  logic [1:0]    alu_op;
  logic          illegal;
  logic [2:0]    st_o;
  logic [CW-1:0] instr_count;

  control_fsm #(.IW(IW), .CW(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .instr_req   (instr_req),
    .instr_ack   (instr_ack),
    .instr_rdata (instr_rdata),
    .ir          (ir),
    .alu_zero    (alu_zero),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_ack    (dmem_ack),
    .pc_en       (pc_en),
    .pc_sel      (pc_sel),
    .rf_we       (rf_we),
    .rf_wsel     (rf_wsel),
    .alu_src     (alu_src),
    .alu_op      (alu_op),
    .illegal     (illegal),
    .state       (st_o),
    .instr_count (instr_count)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       req;
    logic       pce;
    logic [1:0] pcs;
    logic       dreq;
    logic       dwe;
    logic       rfwe;
    logic       rfws;
    logic       asrc;
    logic [1:0] aop;
    logic       ill;
  } obs_t;

  obs_t obs;
  assign obs = {st_o, instr_req, pc_en, pc_sel, dmem_req, dmem_we,
                rf_we, rf_wsel, alu_src, alu_op, illegal};

  int n_chk  = 0;
  int n_fail = 0;
  int mcount = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input obs_t x, input string tag);
    #1;
    n_chk++;
    assert (obs === x) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, x);
    end
  endtask

  task automatic chk_val(input logic [31:0] got, input logic [31:0] exp, input string tag);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Plays one instruction from fetch to retirement, predicting every cycle
  // from the instruction's class and the chosen memory wait / branch outcome.
  task automatic run_instr(input logic [15:0] ins, input int wait_n, input logic zero);
    logic [2:0] op;
    logic [1:0] fn;
    obs_t       x;
    op = ins[15:13];
    fn = ins[12:11];
    chk_val({28'd0, instr_count}, 32'(mcount % 16), "count_pre");
    run = 1'b1; instr_ack = 1'b1; instr_rdata = ins; alu_zero = zero; dmem_ack = 1'b0;
    x = '0; x.req = 1'b1; x.pce = 1'b1;
    chk(x, "fetch");
    cyc();
    run = 1'($urandom_range(0, 1));
    instr_ack = 1'($urandom_range(0, 1));
    instr_rdata = 16'($urandom);
    chk_val({16'd0, ir}, {16'd0, ins}, "ir_latch");
    x = '0; x.st = 3'd1;
    if (op == 3'd5) begin
      x.pce = 1'b1; x.pcs = 2'b10;
      chk(x, "dec_j");
      cyc();
      mcount++;
      return;
    end
    if (op >= 3'd6) begin
      chk(x, "dec_ill");
      cyc();
      return;
    end
    chk(x, "decode");
    cyc();
    x = '0; x.st = 3'd2;
    if (op == 3'd4) begin
      x.aop = 2'b01;
      if (zero) begin x.pce = 1'b1; x.pcs = 2'b01; end
      chk(x, "exec_beq");
      cyc();
      mcount++;
      return;
    end
    if (op == 3'd0) x.aop = fn;
    else x.asrc = 1'b1;
    chk(x, "exec");
    cyc();
    if (op == 3'd2 || op == 3'd3) begin
      for (int i = 0; i <= wait_n; i++) begin
        dmem_ack = (i == wait_n);
        x = '0; x.st = 3'd3; x.dreq = 1'b1; x.dwe = (op == 3'd3);
        chk(x, "mem");
        cyc();
      end
      dmem_ack = 1'b0;
      if (op == 3'd3) begin
        mcount++;
        return;
      end
    end
    x = '0; x.st = 3'd4; x.rfwe = 1'b1; x.rfws = (op == 3'd2);
    chk(x, "wb");
    cyc();
    mcount++;
  endtask

  initial begin
    obs_t x;
    rst_n = 1'b0; run = 1'b0; instr_ack = 1'b0; instr_rdata = '0;
    alu_zero = 1'b0; dmem_ack = 1'b0;
    cyc(); cyc();
    x = '0;
    chk(x, "reset_outputs");
    chk_val({16'd0, ir}, 32'd0, "reset_ir");
    chk_val({28'd0, instr_count}, 32'd0, "reset_count");
    rst_n = 1'b1;

    // run low: acks are ignored and the machine sits in FETCH
    for (int i = 0; i < 3; i++) begin
      run = 1'b0; instr_ack = 1'b1; instr_rdata = 16'hABCD;
      x = '0;
      chk(x, "run_low");
      cyc();
    end
    chk_val({16'd0, ir}, 32'd0, "run_low_ir");

    run_instr(16'h0800, 0, 1'b0);
    run_instr(16'h4000, 3, 1'b0);
    run_instr(16'h8000, 0, 1'b1);
    run_instr(16'h8000, 0, 1'b0);
    chk_val({28'd0, instr_count}, 32'd4, "count_after_directed");

    // SW interrupted by reset while the data request is outstanding
    run = 1'b1; instr_ack = 1'b1; instr_rdata = 16'h6000;
    x = '0; x.req = 1'b1; x.pce = 1'b1;
    chk(x, "sw_fetch");
    cyc();
    instr_ack = 1'b0;
    x = '0; x.st = 3'd1;
    chk(x, "sw_decode");
    cyc();
    x = '0; x.st = 3'd2; x.asrc = 1'b1;
    chk(x, "sw_exec");
    cyc();
    x = '0; x.st = 3'd3; x.dreq = 1'b1; x.dwe = 1'b1;
    chk(x, "sw_mem");
    rst_n = 1'b0; run = 1'b0;
    cyc();
    x = '0;
    chk(x, "sw_reset");
    chk_val({28'd0, instr_count}, 32'd0, "sw_reset_count");
    // reset beats a fetch acknowledged in the same cycle
    run = 1'b1; instr_ack = 1'b1; instr_rdata = 16'h1234;
    cyc();
    run = 1'b0; instr_ack = 1'b0;
    chk_val({16'd0, ir}, 32'd0, "reset_vs_ack_ir");
    chk(x, "reset_vs_ack");
    rst_n = 1'b1;
    mcount = 0;

    // random legal traffic, long enough to wrap the counter
    for (int n = 0; n < 60; n++) begin
      logic [15:0] ins;
      ins = {3'($urandom_range(0, 5)), 13'($urandom)};
      run_instr(ins, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        run = 1'b0; instr_ack = 1'($urandom_range(0, 1));
        x = '0;
        chk(x, "idle");
        cyc();
      end
    end
    chk_val({28'd0, instr_count}, 32'(mcount % 16), "count_random");

    // illegal opcode halts until reset
    run_instr(16'hC000, 0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      run = 1'b1; instr_ack = 1'b1; dmem_ack = 1'b1; alu_zero = 1'b1;
      x = '0; x.st = 3'd5; x.ill = 1'b1;
      chk(x, "halt");
      cyc();
    end
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1; run = 1'b0; instr_ack = 1'b0; dmem_ack = 1'b0;
    x = '0;
    chk(x, "halt_reset");
    chk_val({28'd0, instr_count}, 32'd0, "halt_reset_count");
    mcount = 0;
    run_instr(16'h2000, 0, 1'b0);
    run_instr(16'hA000, 0, 1'b0);
    chk_val({28'd0, instr_count}, 32'd2, "count_final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
